// File: rtl/wb_cmd_master.sv
// Wishbone single-transaction command master.
// Accepts one command, runs one classic Wishbone cycle (terminated by ack
// or by a bounded timeout), then holds the response until it is consumed.
module wb_cmd_master #(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 8,
    parameter int SELECT_W = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // command port
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [SELECT_W-1:0] cmd_sel,
    // response port
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    // Wishbone master port
    output logic [ADDR_W-1:0]   wb_address,
    output logic [DATA_W-1:0]   wb_data_out,
    input  logic [DATA_W-1:0]   wb_data_in,
    output logic                wb_we,
    output logic                wb_stb,
    output logic                wb_cyc,
    output logic [SELECT_W-1:0] wb_sel,
    input  logic                wb_ack
);

    // The counter only ever reaches TIMEOUT-1, so clog2(TIMEOUT) bits never wrap.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  cyc_q;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [SELECT_W-1:0]   sel_q;
    logic                  rsp_valid_q;
    logic [DATA_W-1:0]     rsp_rdata_q;
    logic                  rsp_err_q;

    // Transaction FSM: launch on accept, terminate on ack or timeout, hold response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        we_q    <= cmd_we;
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        sel_q   <= cmd_sel;
                        cyc_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= BUS;
                    end
                end
                BUS: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (wb_ack) begin
                        rsp_rdata_q <= we_q ? '0 : wb_data_in;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        cyc_q       <= 1'b0;
                        state_q     <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        cyc_q       <= 1'b0;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign wb_cyc      = cyc_q;
    assign wb_stb      = cyc_q;
    assign wb_we       = we_q;
    assign wb_address  = addr_q;
    assign wb_data_out = wdata_q;
    assign wb_sel      = sel_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed vector table, random transactions
// against a transaction-level model, and reset / stray-ack sequences.
module tb_wb_cmd_master;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int SW = 4;
    localparam int T  = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] wb_address;
    logic [DW-1:0] wb_data_out, wb_data_in;
    logic          wb_we, wb_stb, wb_cyc, wb_ack;
    logic [SW-1:0] wb_sel;

    int n_tests = 0;
    int n_fail  = 0;

    wb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .SELECT_W(SW), .TIMEOUT(T)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .wb_address(wb_address), .wb_data_out(wb_data_out), .wb_data_in(wb_data_in),
        .wb_we(wb_we), .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_sel(wb_sel),
        .wb_ack(wb_ack)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] sel;
        logic [DW-1:0] slv_rdata;  // data the slave returns with its ack
        int            ack_dly;    // ack in stb cycle ack_dly+1; >= T means never
        int            bp;         // cycles of rsp_ready=0 after the response
        int            exp_cycles; // cycles wb_stb is high
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: how long the bus cycle lasts and what comes back.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_err    = (v.ack_dly >= T);
        r.exp_cycles = r.exp_err ? T : v.ack_dly + 1;
        r.exp_rdata  = (r.exp_err || v.we) ? '0 : v.slv_rdata;
        return r;
    endfunction

    // Drive one command through the DUT acting as slave and response consumer.
    task automatic run_txn(input vec_t v);
        int cycles;
        @(negedge clk_i);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_sel = v.sel;
        @(negedge clk_i);
        cmd_valid = 1'b0;
        cmd_we = ~v.we; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_sel = ~v.sel;
        chk("stb_after_accept", 32'(wb_stb), 32'd1);
        cycles = 0;
        while (wb_stb && cycles < 64) begin
            chk("bus_fields", {wb_cyc, wb_we, wb_address, wb_data_out, wb_sel},
                {1'b1, v.we, v.addr, v.wdata, v.sel});
            chk("cmd_ready_bus", 32'(cmd_ready), 32'd0);
            wb_ack     = (cycles == v.ack_dly);
            wb_data_in = wb_ack ? v.slv_rdata : DW'($urandom);
            cycles++;
            @(negedge clk_i);
        end
        wb_ack = 1'b0;
        chk("stb_cycles", 32'(cycles), 32'(v.exp_cycles));
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_rdata", 32'(rsp_rdata), 32'(v.exp_rdata));
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        chk("cyc_after", 32'(wb_cyc), 32'd0);
        // Backpressure, with a pending command and stray acks that must be ignored.
        for (int i = 0; i < v.bp; i++) begin
            cmd_valid  = 1'b1;
            wb_ack     = 1'($urandom);
            wb_data_in = DW'($urandom);
            @(negedge clk_i);
            chk("bp_hold", {rsp_valid, rsp_rdata, rsp_err, cmd_ready, wb_cyc},
                {1'b1, v.exp_rdata, v.exp_err, 1'b0, 1'b0});
        end
        wb_ack    = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk_i);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("drain", {rsp_valid, cmd_ready, wb_cyc}, {1'b0, 1'b1, 1'b0});
    endtask

    vec_t vecs[6];

    initial begin
        vec_t v;
        rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_sel = '0; rsp_ready = 1'b0; wb_ack = 1'b0; wb_data_in = '0;

        //              we  addr   wdata  sel   slv    dly bp cyc rdata  err
        vecs[0] = '{1'b1, 3'h5, 8'hA7, 4'hF, 8'h99, 2, 0, 3, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 3'h2, 8'h11, 4'h1, 8'h3C, 0, 0, 1, 8'h3C, 1'b0};
        vecs[2] = '{1'b0, 3'h7, 8'h00, 4'h3, 8'hEE, 9, 0, 4, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 3'h1, 8'h00, 4'h8, 8'h55, 3, 0, 4, 8'h55, 1'b0};
        vecs[4] = '{1'b0, 3'h4, 8'h00, 4'h2, 8'hC3, 1, 5, 2, 8'hC3, 1'b0};
        vecs[5] = '{1'b1, 3'h6, 8'h5A, 4'h6, 8'h77, 9, 3, 4, 8'h00, 1'b1};

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_outputs",
            {wb_cyc, wb_stb, wb_we, wb_address, wb_data_out, wb_sel, rsp_valid, rsp_rdata, rsp_err},
            '0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        rst_i = 1'b0;

        foreach (vecs[i]) run_txn(vecs[i]);

        for (int i = 0; i < 40; i++) begin
            v.we        = 1'($urandom);
            v.addr      = AW'($urandom);
            v.wdata     = DW'($urandom);
            v.sel       = SW'($urandom);
            v.slv_rdata = DW'($urandom);
            v.ack_dly   = $urandom_range(0, T + 1);
            v.bp        = $urandom_range(0, 3);
            run_txn(model(v));
        end

        // Reset while the bus cycle is open aborts it with no response.
        @(negedge clk_i);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 3'h3; cmd_wdata = 8'h42; cmd_sel = 4'hA;
        @(negedge clk_i);
        cmd_valid = 1'b0;
        chk("midbus_stb", 32'(wb_stb), 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("midbus_abort", {wb_cyc, wb_stb, rsp_valid, cmd_ready}, {1'b0, 1'b0, 1'b0, 1'b1});
        // Stray acks in IDLE must not create a response or a bus cycle.
        for (int i = 0; i < 3; i++) begin
            wb_ack = 1'b1; wb_data_in = DW'($urandom);
            @(negedge clk_i);
            chk("stray_ack_idle", {rsp_valid, rsp_rdata, rsp_err, wb_cyc, cmd_ready},
                {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        end
        wb_ack = 1'b0;

        // Reset while a response is held discards it.
        run_txn(vecs[1]);
        @(negedge clk_i);
        cmd_valid = 1'b1; cmd_we = 1'b0;
        @(negedge clk_i);
        cmd_valid = 1'b0; wb_ack = 1'b1; wb_data_in = 8'hB4;
        @(negedge clk_i);
        wb_ack = 1'b0;
        chk("resp_pending", 32'(rsp_valid), 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("resp_abort", {rsp_valid, rsp_rdata, cmd_ready, wb_cyc}, {1'b0, 8'h00, 1'b1, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 3, Wishbone address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, Wishbone data width.
REQ-003 The block SHALL have parameter SELECT_W, default 4, Wishbone select width.
REQ-004 The block SHALL have parameter TIMEOUT, default 255, maximum bus cycles to wait for ack (range 1..65535).
REQ-005 The block SHALL use one clock and a synchronous, active-high reset: clk_i  in  1  clock, rising edge; rst_i  in  1  synchronous active-high reset.
REQ-006 The command port SHALL be: cmd_valid  in  1  command present; cmd_ready  out  1  command accepted; cmd_we  in  1  1=write 0=read; cmd_addr  in  ADDR_W  target address; cmd_wdata  in  DATA_W  write data; cmd_sel  in  SELECT_W  byte select.
REQ-007 The response port SHALL be: rsp_valid  out  1  response present; rsp_ready  in  1  response consumed; rsp_rdata  out  DATA_W  read data; rsp_err  out  1  timeout flag.
REQ-008 The Wishbone master port SHALL be: wb_address  out  ADDR_W; wb_data_out  out  DATA_W  write data to slave; wb_data_in  in  DATA_W  read data from slave; wb_we  out  1; wb_stb  out  1; wb_cyc  out  1; wb_sel  out  SELECT_W; wb_ack  in  1.

Function
REQ-009 The block SHALL implement FSM states IDLE, BUS, RESP; exactly one transaction in flight.
REQ-010 In IDLE, cmd_ready SHALL be 1; in BUS and RESP, cmd_ready SHALL be 0.
REQ-011 On the IDLE edge with cmd_valid=1, the block SHALL register cmd_we/addr/wdata/sel onto wb_we/wb_address/wb_data_out/wb_sel, set wb_cyc=wb_stb=1, clear the timeout counter, and enter BUS.
REQ-012 Within BUS, wb_cyc, wb_stb and every Wishbone output SHALL stay constant until termination.
REQ-013 In BUS with wb_ack=1, the block SHALL on that edge capture wb_data_in into rsp_rdata (only when wb_we=0, else rsp_rdata=0), set rsp_err=0, drop wb_cyc/wb_stb, set rsp_valid=1, and enter RESP.
REQ-014 In BUS without wb_ack, the counter SHALL increment each cycle; when it equals TIMEOUT-1 and wb_ack=0, the block SHALL drop wb_cyc/wb_stb, set rsp_rdata=0, rsp_err=1, rsp_valid=1, and enter RESP (bus cycle lasts exactly TIMEOUT cycles).
REQ-015 When wb_ack and the timeout condition coincide, ack SHALL win (rsp_err=0).
REQ-016 Latency: command accepted at edge N -> wb_stb high during cycle N+1; ack sampled at edge M -> wb_stb low and rsp_valid high from cycle M+1; zero-wait slave gives rsp_valid two cycles after acceptance.
REQ-017 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold until an edge with rsp_ready=1, after which rsp_valid=0 and the FSM returns to IDLE.
REQ-018 wb_ack while not in BUS SHALL be ignored (no state or output change).
REQ-019 wb_stb SHALL equal wb_cyc at all times; the counter SHALL be wide enough for TIMEOUT without wrap.

Reset
REQ-020 With rst_i=1 at an edge, the block SHALL enter IDLE and set wb_cyc=0, wb_stb=0, wb_we=0, wb_address=0, wb_data_out=0, wb_sel=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0; cmd_ready=1 after reset.
REQ-021 Reset mid-transaction (BUS or RESP) SHALL abort it: wb_cyc/wb_stb low the following cycle, no response generated.

Verification
REQ-022 Write: cmd we=1 addr=3'h5 wdata=8'hA7 sel=4'hF, slave acks 2 cycles after stb -> wb_address=5, wb_data_out=A7, wb_we=1 held 3 cycles, rsp_valid=1 rsp_err=0 rsp_rdata=0.
REQ-023 Read zero-wait: cmd we=0 addr=3'h2, slave acks same cycle as stb with data 8'h3C -> rsp_valid two cycles after acceptance, rsp_rdata=3C, rsp_err=0.
REQ-024 Timeout: TIMEOUT=4, slave never acks -> wb_stb high exactly 4 cycles, then rsp_err=1, rsp_rdata=0; with ack arriving on the 4th cycle -> rsp_err=0.
REQ-025 Backpressure: rsp_ready=0 for 5 cycles after response -> rsp_valid/rdata/err stable, cmd_ready=0, a pending cmd_valid not accepted until cycle after rsp_ready=1.
REQ-026 Reset mid-BUS: assert rst_i while wb_stb=1 -> next cycle wb_cyc=0, rsp_valid=0, cmd_ready=1; stray wb_ack in IDLE produces no response.
